// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous double buffering.
// Ports: clk_i/rst_i (sync, active high), en_i, load_i, value_i, dp_i, lz_supp_i -> load_ack_o, seg_n_o, dp_n_o, anode_n_o.

module seg7_dec (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);
  // {a,b,c,d,e,f,g}, active low
  always_comb begin
    unique case (hex_i)
      4'h0: seg_n_o = 7'h01;
      4'h1: seg_n_o = 7'h4F;
      4'h2: seg_n_o = 7'h12;
      4'h3: seg_n_o = 7'h06;
      4'h4: seg_n_o = 7'h4C;
      4'h5: seg_n_o = 7'h24;
      4'h6: seg_n_o = 7'h20;
      4'h7: seg_n_o = 7'h0F;
      4'h8: seg_n_o = 7'h00;
      4'h9: seg_n_o = 7'h04;
      4'hA: seg_n_o = 7'h08;
      4'hB: seg_n_o = 7'h60;
      4'hC: seg_n_o = 7'h31;
      4'hD: seg_n_o = 7'h42;
      4'hE: seg_n_o = 7'h30;
      4'hF: seg_n_o = 7'h38;
    endcase
  end
endmodule

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    lz_supp_i,
  output logic                    load_ack_o,
  output logic [6:0]              seg_n_o,
  output logic                    dp_n_o,
  output logic [NUM_DIGITS-1:0]   anode_n_o
);
  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         shown_q, shown_d;
  logic [NUM_DIGITS-1:0] shown_dp_q, shown_dp_d;
  logic [VW-1:0]         pend_q, pend_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  ack_q, ack_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [3:0]            digit;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] supp;
  logic                  slot_end;
  logic                  frame_end;

  assign slot_end  = (state_q == SHOW) && (slot_q == SLOT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  // Scan, buffer and commit all freeze together while disabled.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    idx_d      = idx_q;
    shown_d    = shown_q;
    shown_dp_d = shown_dp_q;
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    if (en_i) begin
      slot_d = slot_end ? '0 : slot_q + 1'b1;
      if (state_q == BLANK) begin
        if (slot_q == BLANK_LAST) state_d = SHOW;
      end else if (slot_end) begin
        state_d = BLANK;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      // Commit before capture so a boundary-cycle load waits a frame.
      if (frame_end && pend_vld_q) begin
        shown_d    = pend_q;
        shown_dp_d = pend_dp_q;
        pend_vld_d = 1'b0;
        ack_d      = 1'b1;
      end
      if (load_i) begin
        pend_d     = value_i;
        pend_dp_d  = dp_i;
        pend_vld_d = 1'b1;
      end
    end
  end

  // Digit i blanks when it and every digit above it are zero.
  always_comb begin
    supp = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      supp[i] = lz_supp_i && ((shown_d >> (4 * i)) == '0);
    end
  end

  assign digit = shown_d[{idx_d, 2'b00} +: 4];

  seg7_dec u_dec (
    .hex_i   (digit),
    .seg_n_o (dec_seg)
  );

  // Outputs are built from next state so they line up with it.
  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    an_d  = '1;
    if (en_i && state_d == SHOW) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = supp[idx_d] ? 7'h7F : dec_seg;
      dp_d  = ~shown_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= BLANK;
      slot_q     <= '0;
      idx_q      <= '0;
      shown_q    <= '0;
      shown_dp_q <= '0;
      pend_q     <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      an_q       <= '1;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      shown_q    <= shown_d;
      shown_dp_q <= shown_dp_d;
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign load_ack_o = ack_q;
  assign seg_n_o    = seg_q;
  assign dp_n_o     = dp_q;
  assign anode_n_o  = an_q;
endmodule
